// File: rtl/seg_pkg.sv
// Shared constants for the four-digit multiplexed display scanner.
// Holds the digit-select codes and the blank/invalid encodings used by the decode.
package seg_pkg;

  localparam logic [3:0] S0          = 4'b0001;
  localparam logic [3:0] S1          = 4'b0010;
  localparam logic [3:0] S2          = 4'b0100;
  localparam logic [3:0] S3          = 4'b1000;
  localparam logic [3:0] BCD_INVALID = 4'b1010;
  localparam logic [3:0] SIDE_OFF    = 4'b0000;

  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    logic [3:0] code;
    case (slot)
      2'd0:    code = S0;
      2'd1:    code = S1;
      2'd2:    code = S2;
      default: code = S3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Per-slot tick divider: counts DIV cycles while enabled and flags the last one.
// cnt_zero lets the parent spot the first cycle of a slot without seeing the counter.
module seg_scan_div #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic cnt_zero
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en)                 cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick     = en && (cnt_q == CNT_MAX);
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/seg_scan.sv
// Four-digit BCD display scanner: steps a slot every DIV cycles and decodes
// the selected digit from a frame-stable shadow copy of value.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic        lz_blank,
  output logic [3:0]  side,
  output logic [3:0]  num_now,
  output logic        frame_start
);

  logic        tick, cnt_zero;
  logic [1:0]  slot_q, slot_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  nib;
  logic        upper_zero, blanked;

  seg_scan_div #(.DIV(DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick     (tick),
    .cnt_zero (cnt_zero)
  );

  // Shadow only follows value at frame boundaries so a frame never tears.
  always_comb begin
    slot_d   = slot_q;
    shadow_d = shadow_q;
    if (!en) begin
      slot_d   = 2'd0;
      shadow_d = value;
    end else if (tick) begin
      slot_d = slot_q + 2'd1;
      if (slot_q == 2'd3) shadow_d = value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= 2'd0;
      shadow_q <= 16'h0000;
    end else begin
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
    end
  end

  // A slot is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    case (slot_q)
      2'd1:    upper_zero = (shadow_q[15:4]  == 12'h000);
      2'd2:    upper_zero = (shadow_q[15:8]  == 8'h00);
      2'd3:    upper_zero = (shadow_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign nib         = shadow_q[{slot_q, 2'b00} +: 4];
  assign blanked     = lz_blank && upper_zero;
  assign side        = (en && !blanked) ? slot_onehot(slot_q) : SIDE_OFF;
  assign num_now     = !en ? 4'b0000 : ((nib > 4'd9) ? BCD_INVALID : nib);
  assign frame_start = en && (slot_q == 2'd0) && cnt_zero;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIV=4: scan order, frame shadowing,
// leading-zero blanking, invalid digits, enable drop and async reset.
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic        lz_blank;
  logic [3:0]  side;
  logic [3:0]  num_now;
  logic        frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan #(.DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value       (value),
    .lz_blank    (lz_blank),
    .side        (side),
    .num_now     (num_now),
    .frame_start (frame_start)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1; en = 1'b0; value = 16'h0000; lz_blank = 1'b0;
  end

  // Restart the scan cleanly: one disabled edge loads the shadow, then enable.
  // Leaves the bench in cycle 0 of a frame (mid low phase), shadow == v.
  task automatic restart(input logic [15:0] v, input logic lz);
    @(negedge clk);
    en = 1'b0; value = v; lz_blank = lz;
    @(negedge clk);
    en = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    rst = 1'b1; en = 1'b0; value = 16'h1234; lz_blank = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b0000, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_en0 got=%b exp=%b", obs, {4'b0000, 4'b0000, 1'b0});
    end
    en = 1'b1;
    @(negedge clk); #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b0001, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL reset_en1 got=%b exp=%b", obs, {4'b0001, 4'b0000, 1'b1});
    end
  endtask

  // Release reset with value=0x1234: first frame shows zeros, second shows 4,3,2,1.
  task automatic test_scan_order;
    logic [15:0] shown;
    logic [8:0]  obs, exp;
    int s;
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      s     = (c % 16) / 4;
      shown = (c < 16) ? 16'h0000 : 16'h1234;
      exp   = {4'b0001 << s, shown[s*4 +: 4], (c % 16) == 0};
      obs   = {side, num_now, frame_start};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL scan_order c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  // Value changes at cycle 5 of a frame: current frame keeps 0x1234, next shows 0x5678.
  task automatic test_frame_shadow;
    logic [15:0] shown;
    logic [8:0]  obs, exp;
    int s;
    restart(16'h1234, 1'b0);
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c == 5) value = 16'h5678;
      #1;
      s     = (c % 16) / 4;
      shown = (c < 16) ? 16'h1234 : 16'h5678;
      exp   = {4'b0001 << s, shown[s*4 +: 4], (c % 16) == 0};
      obs   = {side, num_now, frame_start};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL frame_shadow c=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_lz_blank;
    logic [7:0] obs;
    logic [7:0] exp45 [4];
    logic [7:0] exp00 [4];
    exp45[0] = {4'b0001, 4'd5}; exp45[1] = {4'b0010, 4'd4};
    exp45[2] = {4'b0000, 4'd0}; exp45[3] = {4'b0000, 4'd0};
    exp00[0] = {4'b0001, 4'd0}; exp00[1] = {4'b0000, 4'd0};
    exp00[2] = {4'b0000, 4'd0}; exp00[3] = {4'b0000, 4'd0};
    restart(16'h0045, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c % 4 == 1) begin
        obs = {side, num_now};
        n_checks++;
        if (obs !== exp45[c/4]) begin
          n_fail++; $display("FAIL lz_0045 slot=%0d got=%b exp=%b", c/4, obs, exp45[c/4]);
        end
      end
    end
    restart(16'h0000, 1'b1);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c % 4 == 2) begin
        obs = {side, num_now};
        n_checks++;
        if (obs !== exp00[c/4]) begin
          n_fail++; $display("FAIL lz_0000 slot=%0d got=%b exp=%b", c/4, obs, exp00[c/4]);
        end
      end
    end
  endtask

  task automatic test_invalid_digit;
    logic [7:0] obs;
    logic [7:0] exp [3];
    exp[0] = {4'b0001, 4'b0111};
    exp[1] = {4'b0010, 4'b1010};
    exp[2] = {4'b0100, 4'b0000};
    restart(16'h00C7, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (c % 4 == 3) begin
        obs = {side, num_now};
        n_checks++;
        if (obs !== exp[c/4]) begin
          n_fail++; $display("FAIL invalid_00C7 slot=%0d got=%b exp=%b", c/4, obs, exp[c/4]);
        end
      end
    end
  endtask

  task automatic test_enable_drop;
    logic [8:0] obs;
    restart(16'h1234, 1'b0);
    repeat (9) @(negedge clk);
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b0100, 4'd2, 1'b0}) begin
      n_fail++; $display("FAIL en_drop_pre got=%b exp=%b", obs, {4'b0100, 4'd2, 1'b0});
    end
    en = 1'b0;
    @(negedge clk); #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++; $display("FAIL en_drop_dark got=%b exp=%b", obs, 9'b0);
    end
    value = 16'h9001;
    @(negedge clk);
    en = 1'b1;
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b0001, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL en_raise got=%b exp=%b", obs, {4'b0001, 4'd1, 1'b1});
    end
    repeat (12) @(negedge clk);
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b1000, 4'd9, 1'b0}) begin
      n_fail++; $display("FAIL en_raise_slot3 got=%b exp=%b", obs, {4'b1000, 4'd9, 1'b0});
    end
  endtask

  // Reset pulsed between edges in slot 3: immediate restart, slot 0 then lasts 4 cycles.
  task automatic test_async_reset;
    logic [8:0] obs;
    logic [3:0] exp_side;
    restart(16'h1234, 1'b0);
    repeat (13) @(negedge clk);
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b1000, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL rst_pre got=%b exp=%b", obs, {4'b1000, 4'd1, 1'b0});
    end
    #1 rst = 1'b1;
    #1;
    obs = {side, num_now, frame_start};
    n_checks++;
    if (obs !== {4'b0001, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL rst_immediate got=%b exp=%b", obs, {4'b0001, 4'd0, 1'b1});
    end
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      exp_side = (k < 4) ? 4'b0001 : 4'b0010;
      n_checks++;
      if (side !== exp_side || num_now !== 4'd0) begin
        n_fail++; $display("FAIL rst_slot0_len k=%0d side=%b num=%b exp_side=%b exp_num=0000",
                           k, side, num_now, exp_side);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_frame_shadow();
    test_lz_blank();
    test_invalid_digit();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The module SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot (legal range DIV >= 2).
REQ-002 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port en  input  1  scan enable; 0 = display dark and scan held.
REQ-005 Port value  input  16  four BCD digits; nibble k = value[4k+3:4k], slot 0 = least significant digit.
REQ-006 Port lz_blank  input  1  1 = suppress leading zeros.
REQ-007 Port side  output  4  one-hot digit select (0001 = slot 0 ... 1000 = slot 3); 0000 = digit dark.
REQ-008 Port num_now  output  4  BCD digit code for the selected slot, consumed by the segment encoder.
REQ-009 Port frame_start  output  1  single-cycle pulse marking the first cycle of each frame.

Function
REQ-010 The module SHALL hold a tick counter cnt (0..DIV-1), a 2-bit slot register and a 16-bit shadow register.
REQ-011 When en=1, cnt SHALL increment each cycle and wrap DIV-1 -> 0; on that wrap, slot SHALL advance 0->1->2->3->0.
REQ-012 When en=0, cnt and slot SHALL be forced to 0 on every edge.
REQ-013 Shadow SHALL load value on every edge where en=0, and on the edge where slot wraps 3->0 with cnt=DIV-1; otherwise it SHALL hold.
REQ-014 Value changes mid-frame SHALL NOT affect side/num_now until the next frame.
REQ-015 side and num_now SHALL be combinational decodes of the slot, shadow, en and lz_blank registers and inputs, with zero added latency.
REQ-016 num_now SHALL equal shadow nibble[slot] when that nibble <= 9, and 4'b1010 when it is 10..15.
REQ-017 side SHALL equal the one-hot code of slot when en=1 and the slot is not blanked; otherwise it SHALL be 0000.
REQ-018 Slot k (k = 1..3) is blanked when lz_blank=1 and shadow nibbles k..3 are all zero.
REQ-019 Slot 0 SHALL never be blanked; value 0x0000 with lz_blank=1 SHALL show only slot 0 = 0.
REQ-020 When en=0, num_now SHALL be 0000.
REQ-021 frame_start SHALL equal en AND slot=0 AND cnt=0, including the first enabled cycle after reset or after en rises.

Reset
REQ-022 Asserting rst SHALL immediately clear cnt, slot and shadow to 0, regardless of clk.
REQ-023 During and after reset, the outputs SHALL decode from these cleared values: side=0001 if en=1, else 0000; num_now=0000; frame_start=en.
REQ-024 Reset asserted mid-slot or mid-frame SHALL abort the scan; on release, the scan SHALL restart at slot 0, cnt 0.
REQ-025 The first frame after reset with en=1 SHALL display shadow=0.

Structure
REQ-026 Shared package seg_pkg SHALL hold the slot one-hot constants S0..S3 (0001/0010/0100/1000), the constant BCD_INVALID = 4'b1010 and the constant SIDE_OFF = 4'b0000.
REQ-027 The cnt counter and its wrap-tick generation SHALL be implemented in one sub-module, seg_scan_div, with parameter DIV, inputs clk/rst/en and output tick (cnt=DIV-1 and en); cnt width SHALL be $clog2(DIV).
REQ-028 The slot register, shadow register and output decode SHALL reside in seg_scan.

Verification (DIV=4)
REQ-029 Bench SHALL cover: rst, en=1, value=0x1234 -> cycles 0-15: side 0001/0010/0100/1000 for 4 cycles each, num_now 0; cycle 16: frame_start=1 and slots show 4,3,2,1.
REQ-030 Bench SHALL cover: value changes 0x1234->0x5678 at cycle 5 of a frame -> current frame still shows 4,3,2,1; next frame shows 8,7,6,5.
REQ-031 Bench SHALL cover: lz_blank=1, value=0x0045 -> slots 2 and 3 side=0000, slot1 num 4, slot0 num 5; value=0x0000 -> only slot 0 is lit, num 0.
REQ-032 Bench SHALL cover: value=0x00C7 -> slot1 num_now=1010, slot0 num_now=0111.
REQ-033 Bench SHALL cover: en dropped in slot 2, cnt=1 -> next cycle side=0000 and num_now=0000; en re-raised with value=0x9001 -> same cycle frame_start=1, side=0001, num_now=1.
REQ-034 Bench SHALL cover: rst pulsed between clock edges during slot 3 -> outputs change immediately to side=0001, num_now=0000; after release, slot0 lasts exactly 4 cycles.
